// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: fetch FSM states, reset PC and opcode encodings.
package slc3_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_PSE  = 4'b1101;

    // Opcode field as consumed by decode.
    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read handshake plus IR/valid/accept to decode.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] IR;
    logic              ir_valid;
    logic              ir_accept;

    modport master (
        output mem_addr, mem_rd, IR, ir_valid,
        input  mem_ready, mem_rdata, ir_accept
    );

    modport slave (
        input  mem_addr, mem_rd, IR, ir_valid,
        output mem_ready, mem_rdata, ir_accept
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter register: Reset > load > increment, wrapping modulo 2^ADDR_W.
module fetch_pc #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC/IR ownership, multi-cycle instruction read, IR handoff to decode.
module instr_fetch_unit
    import slc3_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                WAIT_MAX = 255
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_target,
    output logic [ADDR_W-1:0]   PC,
    output logic                fetch_fault,
    instr_fetch_unit_if.master  bus
);
    localparam int                CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    fetch_state_t      state_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              fault_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              pc_inc;

    // Redirect outranks the increment inside fetch_pc, so an abort never advances PC.
    assign pc_inc = (state_q == F_WAIT) && bus.mem_ready;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .Clk      (Clk),
        .Reset    (Reset),
        .load_i   (pc_load),
        .inc_i    (pc_inc),
        .target_i (pc_target),
        .pc_o     (PC)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= F_IDLE;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (Run && !fault_q) begin
                        state_q <= F_REQ;
                    end
                end
                F_REQ: begin
                    // A redirect landing here is issued directly, keeping mem_addr equal to PC.
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= pc_load ? pc_target : PC;
                    wait_cnt_q <= '0;
                    state_q    <= F_WAIT;
                end
                F_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    if (pc_load) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= F_REQ;
                    end else if (bus.mem_ready) begin
                        ir_q       <= bus.mem_rdata;
                        ir_valid_q <= 1'b1;
                        mem_rd_q   <= 1'b0;
                        state_q    <= F_HOLD;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        fault_q  <= 1'b1;
                        mem_rd_q <= 1'b0;
                        state_q  <= F_IDLE;
                    end
                end
                F_HOLD: begin
                    if (bus.ir_accept || pc_load) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= Run ? F_REQ : F_IDLE;
                    end
                end
                default: begin
                    state_q <= F_IDLE;
                end
            endcase
        end
    end

    assign bus.IR       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign fetch_fault  = fault_q;
endmodule
